branch_issue_queue: RTL and testbench

BRANCH_ISSUE_QUEUE -- requirements
Module: branch_issue_queue

---
 rtl/branch_issue_queue_pkg.sv | 23 ++
 rtl/branch_issue_queue_picker.sv | 41 ++++
 rtl/branch_issue_queue.sv | 171 +++++++++++++++++
 tb/tb_branch_issue_queue.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_issue_queue_pkg.sv
// Shared constants for the branch issue queue.
// Operand/tag defaults and branch opcode encodings.
package branch_issue_queue_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int TAG_W_DEF  = 5;
  localparam int TAG_READY  = 0;

  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] FN_JR     = 6'b001000;

  function automatic logic is_branch_op(
    input logic [5:0] op
  );
    return op inside {OP_BEQ, OP_BNE, OP_REGIMM,
                      OP_J, OP_JAL};
  endfunction

endpackage

// File: rtl/branch_issue_queue_picker.sv
// Oldest-ready selection from an age matrix.
// age[j*DEPTH+i] set means entry j is older than i.
module oldest_ready_picker
  import branch_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
)(
  input  logic [DEPTH*DEPTH-1:0] age,
  input  logic [DEPTH-1:0]       ready,
  output logic [DEPTH-1:0]       grant,
  output logic [IDX_W-1:0]       idx,
  output logic                   any
);

  // an entry wins when no other ready entry is older
  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic older;
      older = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && ready[j] && age[j*DEPTH+i])
          older = 1'b1;
      end
      grant[i] = ready[i] && !older;
    end
  end

  // encode the one-hot winner
  always_comb begin
    idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (grant[i])
        idx = IDX_W'(i);
    end
  end

  assign any = |ready;

endmodule

// File: rtl/branch_issue_queue.sv
// Branch reservation station: wakeup, oldest-first
// selection, and predictor update after a grant.
module branch_issue_queue
  import branch_issue_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = $clog2(DEPTH+1),
  parameter int IDX_W  = $clog2(DEPTH)
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       issue,
  input  logic [DATA_W-1:0]          issue_vj,
  input  logic [DATA_W-1:0]          issue_vk,
  input  logic [TAG_W-1:0]           issue_qj,
  input  logic [TAG_W-1:0]           issue_qk,
  input  logic [TAG_W-1:0]           issue_tag,
  input  logic [DATA_W-1:0]          issue_pc,
  input  logic [DATA_W-1:0]          issue_inst,
  input  logic                       cdb_en,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  output logic                       full,
  output logic [CNT_W-1:0]           count,
  output logic                       req_bus,
  input  logic                       bus_granted,
  output logic [DATA_W-1:0]          out_vj,
  output logic [DATA_W-1:0]          out_vk,
  output logic [DATA_W-1:0]          out_pc,
  output logic [DATA_W-1:0]          out_inst,
  output logic [TAG_W-1:0]           out_tag,
  input  logic [DATA_W-1:0]          branch_result,
  output logic [3*DATA_W+TAG_W-1:0]  cdb_out,
  output logic                       upd_en,
  output logic [DATA_W-1:0]          upd_pc,
  output logic                       upd_taken
);

  localparam logic [TAG_W-1:0] RDY = TAG_W'(TAG_READY);

  logic [DEPTH-1:0]             valid;
  logic [DEPTH-1:0][DEPTH-1:0]  age;
  logic [DATA_W-1:0]            vj   [DEPTH];
  logic [DATA_W-1:0]            vk   [DEPTH];
  logic [DATA_W-1:0]            pc   [DEPTH];
  logic [DATA_W-1:0]            inst [DEPTH];
  logic [TAG_W-1:0]             qj   [DEPTH];
  logic [TAG_W-1:0]             qk   [DEPTH];
  logic [TAG_W-1:0]             tag  [DEPTH];

  logic [DEPTH-1:0]  ready;
  logic [DEPTH-1:0]  sel_oh;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  free_idx;
  logic              iss_ok;
  logic              gnt_ok;
  logic              byp_j;
  logic              byp_k;

  // ready vector, free slot and occupancy
  always_comb begin
    ready    = '0;
    free_idx = '0;
    count    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = valid[i] && qj[i] == RDY
                 && qk[i] == RDY;
      count = count + CNT_W'(valid[i]);
    end
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!valid[i])
        free_idx = IDX_W'(i);
    end
  end

  assign full   = &valid;
  assign iss_ok = issue && !full && !flush;
  assign gnt_ok = bus_granted && req_bus && !flush;
  assign byp_j  = cdb_en && issue_qj != RDY
                  && issue_qj == cdb_tag;
  assign byp_k  = cdb_en && issue_qk != RDY
                  && issue_qk == cdb_tag;

  oldest_ready_picker #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_picker (
    .age   (age),
    .ready (ready),
    .grant (sel_oh),
    .idx   (sel_idx),
    .any   (req_bus)
  );

  // valid bits and age matrix
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= '0;
      age   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (gnt_ok && sel_oh[i])
          valid[i] <= 1'b0;
      end
      if (iss_ok) begin
        valid[free_idx] <= 1'b1;
        for (int j = 0; j < DEPTH; j++) begin
          if (IDX_W'(j) != free_idx) begin
            age[j][free_idx] <= 1'b1;
            age[free_idx][j] <= 1'b0;
          end
        end
      end
    end
  end

  // operand wakeup and new-entry write
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && cdb_en && qj[i] != RDY
          && qj[i] == cdb_tag) begin
        vj[i] <= cdb_data;
        qj[i] <= RDY;
      end
      if (valid[i] && cdb_en && qk[i] != RDY
          && qk[i] == cdb_tag) begin
        vk[i] <= cdb_data;
        qk[i] <= RDY;
      end
      if (iss_ok && free_idx == IDX_W'(i)) begin
        vj[i]   <= byp_j ? cdb_data : issue_vj;
        qj[i]   <= byp_j ? RDY : issue_qj;
        vk[i]   <= byp_k ? cdb_data : issue_vk;
        qk[i]   <= byp_k ? RDY : issue_qk;
        tag[i]  <= issue_tag;
        pc[i]   <= issue_pc;
        inst[i] <= issue_inst;
      end
    end
  end

  assign out_vj   = vj[sel_idx];
  assign out_vk   = vk[sel_idx];
  assign out_pc   = pc[sel_idx];
  assign out_inst = inst[sel_idx];
  assign out_tag  = tag[sel_idx];
  assign cdb_out  = {out_vj, out_vk, out_tag,
                     branch_result};

  // one-cycle predictor update after a grant
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_en    <= 1'b0;
      upd_pc    <= '0;
      upd_taken <= 1'b0;
    end else if (flush) begin
      upd_en <= 1'b0;
    end else begin
      upd_en <= gnt_ok;
      if (gnt_ok) begin
        upd_pc    <= out_pc;
        upd_taken <= (out_pc + DATA_W'(8))
                     != branch_result;
      end
    end
  end

endmodule

// File: tb/tb_branch_issue_queue.sv
// Bench for branch_issue_queue: DEPTH=4 and DEPTH=8
// instances on shared stimulus, checked against a model.
module tb_branch_issue_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, issue, cdb_en, bus_granted;
  logic [31:0] issue_vj, issue_vk, issue_pc, issue_inst;
  logic [31:0] cdb_data, branch_result;
  logic [5:0]  issue_qj, issue_qk, issue_tag, cdb_tag;

  logic         full0, req0, ue0, ut0;
  logic [2:0]   count0;
  logic [31:0]  ovj0, ovk0, opc0, oinst0, upc0;
  logic [4:0]   otag0;
  logic [100:0] cdbo0;

  logic         full1, req1, ue1, ut1;
  logic [3:0]   count1;
  logic [31:0]  ovj1, ovk1, opc1, oinst1, upc1;
  logic [5:0]   otag1;
  logic [101:0] cdbo1;

  branch_issue_queue #(.DEPTH(4), .TAG_W(5)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .issue(issue),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj(issue_qj[4:0]), .issue_qk(issue_qk[4:0]),
    .issue_tag(issue_tag[4:0]), .issue_pc(issue_pc),
    .issue_inst(issue_inst), .cdb_en(cdb_en),
    .cdb_tag(cdb_tag[4:0]), .cdb_data(cdb_data),
    .full(full0), .count(count0), .req_bus(req0),
    .bus_granted(bus_granted), .out_vj(ovj0),
    .out_vk(ovk0), .out_pc(opc0), .out_inst(oinst0),
    .out_tag(otag0), .branch_result(branch_result),
    .cdb_out(cdbo0), .upd_en(ue0), .upd_pc(upc0),
    .upd_taken(ut0)
  );

  branch_issue_queue #(.DEPTH(8), .TAG_W(6)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .issue(issue),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_tag(issue_tag), .issue_pc(issue_pc),
    .issue_inst(issue_inst), .cdb_en(cdb_en),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .full(full1), .count(count1), .req_bus(req1),
    .bus_granted(bus_granted), .out_vj(ovj1),
    .out_vk(ovk1), .out_pc(opc1), .out_inst(oinst1),
    .out_tag(otag1), .branch_result(branch_result),
    .cdb_out(cdbo1), .upd_en(ue1), .upd_pc(upc1),
    .upd_taken(ut1)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // model: unordered slots, age by issue sequence number
  logic        mv    [2][8];
  logic [31:0] mvj   [2][8];
  logic [31:0] mvk   [2][8];
  logic [31:0] mpc   [2][8];
  logic [31:0] minst [2][8];
  int          mqj   [2][8];
  int          mqk   [2][8];
  int          mtag  [2][8];
  int          mseq  [2][8];
  int          seq_ctr = 0;
  logic        mue  [2];
  logic [31:0] mupc [2];
  logic        mut  [2];

  task automatic chk(string name, logic [127:0] act,
                     logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  function automatic int m_cap(int d);
    return (d == 0) ? 4 : 8;
  endfunction

  function automatic int m_count(int d);
    int c = 0;
    for (int i = 0; i < 8; i++)
      if (mv[d][i]) c++;
    return c;
  endfunction

  function automatic int m_sel(int d);
    int s = -1;
    for (int i = 0; i < 8; i++)
      if (mv[d][i] && mqj[d][i] == 0 && mqk[d][i] == 0
          && (s < 0 || mseq[d][i] < mseq[d][s]))
        s = i;
    return s;
  endfunction

  task automatic compare(int d, int cnt, logic fl,
                         logic rq, logic [31:0] vj,
                         logic [31:0] vk, logic [31:0] pc,
                         logic [31:0] inst, int tg,
                         logic [127:0] co, logic ue,
                         logic [31:0] upc, logic ut);
    int s;
    int c;
    logic [127:0] eco;
    s = m_sel(d);
    c = m_count(d);
    chk($sformatf("d%0d.count", d), 128'(cnt), 128'(c));
    chk($sformatf("d%0d.full", d), 128'(fl),
        128'(c == m_cap(d)));
    chk($sformatf("d%0d.req_bus", d), 128'(rq),
        128'(s >= 0));
    if (s >= 0) begin
      chk($sformatf("d%0d.out_vj", d), 128'(vj),
          128'(mvj[d][s]));
      chk($sformatf("d%0d.out_vk", d), 128'(vk),
          128'(mvk[d][s]));
      chk($sformatf("d%0d.out_pc", d), 128'(pc),
          128'(mpc[d][s]));
      chk($sformatf("d%0d.out_inst", d), 128'(inst),
          128'(minst[d][s]));
      chk($sformatf("d%0d.out_tag", d), 128'(tg),
          128'(mtag[d][s]));
      if (d == 0)
        eco = {27'b0, mvj[d][s], mvk[d][s],
               5'(mtag[d][s]), branch_result};
      else
        eco = {26'b0, mvj[d][s], mvk[d][s],
               6'(mtag[d][s]), branch_result};
      chk($sformatf("d%0d.cdb_out", d), co, eco);
    end
    chk($sformatf("d%0d.upd_en", d), 128'(ue),
        128'(mue[d]));
    if (mue[d]) begin
      chk($sformatf("d%0d.upd_pc", d), 128'(upc),
          128'(mupc[d]));
      chk($sformatf("d%0d.upd_taken", d), 128'(ut),
          128'(mut[d]));
    end
  endtask

  task automatic m_step(int d);
    int s;
    int c;
    int f;
    logic gok;
    s = m_sel(d);
    c = m_count(d);
    if (rst) begin
      for (int i = 0; i < 8; i++) mv[d][i] = 1'b0;
      mue[d] = 1'b0;
      mupc[d] = '0;
      mut[d] = 1'b0;
      return;
    end
    if (flush) begin
      for (int i = 0; i < 8; i++) mv[d][i] = 1'b0;
      mue[d] = 1'b0;
      return;
    end
    gok = bus_granted && s >= 0;
    mue[d] = gok;
    if (gok) begin
      mupc[d] = mpc[d][s];
      mut[d] = (mpc[d][s] + 32'd8) != branch_result;
    end
    for (int i = 0; i < 8; i++) begin
      if (mv[d][i] && cdb_en) begin
        if (mqj[d][i] != 0 && mqj[d][i] == int'(cdb_tag)) begin
          mvj[d][i] = cdb_data;
          mqj[d][i] = 0;
        end
        if (mqk[d][i] != 0 && mqk[d][i] == int'(cdb_tag)) begin
          mvk[d][i] = cdb_data;
          mqk[d][i] = 0;
        end
      end
    end
    if (gok) mv[d][s] = 1'b0;
    if (issue && c < m_cap(d)) begin
      f = -1;
      for (int i = 0; i < 8; i++)
        if (!mv[d][i] && f < 0) f = i;
      mv[d][f] = 1'b1;
      mpc[d][f] = issue_pc;
      minst[d][f] = issue_inst;
      mtag[d][f] = int'(issue_tag);
      mseq[d][f] = seq_ctr;
      if (cdb_en && issue_qj != 0 && issue_qj == cdb_tag) begin
        mvj[d][f] = cdb_data;
        mqj[d][f] = 0;
      end else begin
        mvj[d][f] = issue_vj;
        mqj[d][f] = int'(issue_qj);
      end
      if (cdb_en && issue_qk != 0 && issue_qk == cdb_tag) begin
        mvk[d][f] = cdb_data;
        mqk[d][f] = 0;
      end else begin
        mvk[d][f] = issue_vk;
        mqk[d][f] = int'(issue_qk);
      end
    end
  endtask

  task automatic tick();
    #1;
    if (chk_en) begin
      compare(0, int'(count0), full0, req0, ovj0, ovk0,
              opc0, oinst0, int'(otag0), {27'b0, cdbo0},
              ue0, upc0, ut0);
      compare(1, int'(count1), full1, req1, ovj1, ovk1,
              opc1, oinst1, int'(otag1), {26'b0, cdbo1},
              ue1, upc1, ut1);
    end
    m_step(0);
    m_step(1);
    seq_ctr++;
    @(posedge clk);
    @(negedge clk);
    issue       = 1'b0;
    flush       = 1'b0;
    bus_granted = 1'b0;
    cdb_en      = 1'b0;
  endtask

  task automatic do_issue(logic [31:0] pc, int qj, int qk,
                          logic [31:0] vj, int tg);
    issue      = 1'b1;
    issue_pc   = pc;
    issue_inst = pc ^ 32'h1000_0004;
    issue_qj   = 6'(qj);
    issue_qk   = 6'(qk);
    issue_vj   = vj;
    issue_vk   = ~vj;
    issue_tag  = 6'(tg);
  endtask

  task automatic rand_tag(output int t);
    t = ($urandom_range(0, 2) == 0) ? 0
        : int'($urandom_range(1, 6));
  endtask

  initial begin
    int a;
    int b;
    rst = 1'b1; flush = 1'b0; issue = 1'b0;
    cdb_en = 1'b0; bus_granted = 1'b0;
    issue_vj = '0; issue_vk = '0; issue_pc = '0;
    issue_inst = '0; cdb_data = '0; branch_result = '0;
    issue_qj = '0; issue_qk = '0; issue_tag = '0;
    cdb_tag = '0;
    for (int i = 0; i < 8; i++) begin
      mv[0][i] = 1'b0;
      mv[1][i] = 1'b0;
    end
    @(negedge clk);
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst.count", 128'(count0), 128'(0));
    chk("rst.full", 128'(full0), 128'(0));
    chk("rst.req_bus", 128'(req0), 128'(0));
    chk("rst.upd_en", 128'(ue0), 128'(0));
    chk("rst.upd_pc", 128'(upc0), 128'(0));
    chk("rst.upd_taken", 128'(ut0), 128'(0));

    for (int i = 0; i < 5; i++) begin
      do_issue(32'h100 + 32'(i * 16), 0, 0, 32'(i), i + 1);
      tick();
      if (i == 3) begin
        chk("fill.full", 128'(full0), 128'(1));
        chk("fill.count", 128'(count0), 128'(4));
      end
    end
    chk("fill5.count", 128'(count0), 128'(4));
    chk("fill5.count8", 128'(count1), 128'(5));
    for (int i = 0; i < 5; i++) begin
      if (i < 4)
        chk("drain.order", 128'(opc0),
            128'(32'h100 + 32'(i * 16)));
      bus_granted = 1'b1;
      branch_result = 32'h100 + 32'(i * 16) + 32'd8;
      tick();
    end
    tick();
    chk("drain.empty", 128'(count1), 128'(0));

    do_issue(32'h100, 0, 0, 32'h11, 9);
    tick();
    do_issue(32'h100, 0, 0, 32'h22, 10);
    tick();
    bus_granted = 1'b1;
    branch_result = 32'h108;
    tick();
    chk("upd.en0", 128'(ue0), 128'(1));
    chk("upd.pc0", 128'(upc0), 128'(32'h100));
    chk("upd.nt", 128'(ut0), 128'(0));
    bus_granted = 1'b1;
    branch_result = 32'h200;
    tick();
    chk("upd.en1", 128'(ue0), 128'(1));
    chk("upd.pc1", 128'(upc0), 128'(32'h100));
    chk("upd.tk", 128'(ut0), 128'(1));
    tick();
    chk("upd.off", 128'(ue0), 128'(0));

    do_issue(32'hA00, 3, 0, 32'h0, 11);
    tick();
    do_issue(32'hB00, 0, 0, 32'h7, 12);
    tick();
    chk("wake.first", 128'(opc0), 128'(32'hB00));
    cdb_en = 1'b1; cdb_tag = 6'd3; cdb_data = 32'h55;
    bus_granted = 1'b1; branch_result = 32'hB08;
    do_issue(32'hC00, 3, 0, 32'h0, 13);
    tick();
    chk("wake.pc", 128'(opc0), 128'(32'hA00));
    chk("wake.vj", 128'(ovj0), 128'(32'h55));
    bus_granted = 1'b1;
    tick();
    chk("byp.pc", 128'(opc0), 128'(32'hC00));
    chk("byp.vj", 128'(ovj0), 128'(32'h55));
    bus_granted = 1'b1;
    tick();

    do_issue(32'hD00, 7, 0, 32'h0, 14);
    cdb_en = 1'b1; cdb_tag = 6'd7; cdb_data = 32'h1234;
    tick();
    chk("byp7.req", 128'(req0), 128'(1));
    chk("byp7.vj", 128'(ovj0), 128'(32'h1234));
    bus_granted = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) begin
      do_issue(32'hE00 + 32'(i * 4), 0, 0, 32'(i), 15 + i);
      tick();
    end
    do_issue(32'hF00, 0, 0, 32'h9, 20);
    bus_granted = 1'b1;
    flush = 1'b1;
    tick();
    chk("flush.count", 128'(count0), 128'(0));
    chk("flush.req", 128'(req0), 128'(0));
    chk("flush.upd", 128'(ue0), 128'(0));
    tick();

    for (int i = 0; i < 8; i++) begin
      rand_tag(a);
      rand_tag(b);
      do_issue($urandom, a, b, $urandom, 20 + i);
      tick();
    end
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) < 7) begin
        cdb_en = 1'b1;
        cdb_tag = 6'($urandom_range(1, 6));
        cdb_data = $urandom;
      end
      if ($urandom_range(0, 9) < 4) begin
        rand_tag(a);
        rand_tag(b);
        do_issue($urandom, a, b, $urandom,
                 int'($urandom_range(1, 31)));
      end
      if ($urandom_range(0, 1) == 1) begin
        bus_granted = 1'b1;
        branch_result = (n % 3 == 0) ? opc1 + 32'd8
                                     : $urandom;
      end
      tick();
    end
    for (int n = 0; n < 30; n++) begin
      cdb_en = 1'b1;
      cdb_tag = 6'(1 + (n % 6));
      cdb_data = $urandom;
      bus_granted = 1'b1;
      branch_result = $urandom;
      tick();
    end
    chk("rand.drained", 128'(count1), 128'(0));

    do_issue(32'h400, 0, 0, 32'h1, 1);
    tick();
    do_issue(32'h404, 0, 0, 32'h2, 2);
    tick();
    bus_granted = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid.upd", 128'(ue1), 128'(0));
    chk("rstmid.count", 128'(count1), 128'(0));
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
